wshb_arbiter: RTL
=================

Name: wshb_arbiter

Overview:
- Two-master / one-slave Wishbone arbiter that shares the SDRAM Wishbone slave port of hw_support.
- Master 0 is the video frame reader (high bandwidth); master 1 is the pattern/frame writer.
- Grant is held for a whole Wishbone cycle (cyc high). Selection is round-robin or fixed-priority.
- Sits in Top between the two internal masters and wshb_if_sdram.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = master 0 always wins ties.

Ports:
- sys_clk  in  1  system clock (100 MHz); all state on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- wshb_ifs_0  wshb_if slave modport  DATA_BYTES=4  master 0 request port.
- wshb_ifs_1  wshb_if slave modport  DATA_BYTES=4  master 1 request port.
- wshb_ifm  wshb_if master modport  DATA_BYTES=4  to the SDRAM slave.
- gnt  out  2  one-hot current owner (bit i = master i); 00 = bus free.

Behaviour:
- Request: req_i = wshb_ifs_i.cyc. stb without cyc is ignored.
- State: registered gnt[1:0] and last[0:0] (last granted master).
- Reset values: gnt = 00, last = 1, so master 0 wins the first tie.
- On reset assert, gnt clears immediately (async). While gnt = 00, wshb_ifm.cyc and stb = 0.
- FSM states: IDLE (gnt=00), OWN0 (gnt=01), OWN1 (gnt=10).
- IDLE:
  - only req0 -> OWN0; only req1 -> OWN1.
  - both, FIXED_PRIO=1 -> OWN0.
  - both, FIXED_PRIO=0 -> the master != last.
  - none -> stay in IDLE.
- OWNi:
  - stay while req_i = 1, regardless of the other master.
  - when req_i = 0, re-arbitrate in that same cycle using the IDLE rules, with last updated to i.
  - result: a waiting master takes ownership on the next edge, with no extra idle cycle.
- last is updated to i on every entry into OWNi.
- Grant latency: a request seen in IDLE reaches the slave 1 cycle later. The master must hold cyc/stb/adr until ack (standard Wishbone).
- Master->slave path (combinational mux on registered gnt):
  - cyc, stb = owner.cyc & owner.stb-gated.
  - Specifically, wshb_ifm.cyc = owner.cyc and wshb_ifm.stb = owner.stb & owner.cyc, so dropping cyc removes the request in that same cycle.
  - we, adr, dat_ms, sel, cti, bte taken from the owner; all '0 in IDLE.
- Slave->master path:
  - ack, err, rty routed only to the owner; the non-owner sees 0.
  - dat_sm broadcast to both masters.
- Non-owner waiting with cyc=stb=1 sees no ack until granted; it is never lost.
- No preemption: an owner holding cyc indefinitely starves the other master. Masters release cyc after each burst.
- Simultaneous release and new request from the same master (cyc low for exactly one cycle): re-arbitration occurs and round-robin applies. Under FIXED_PRIO=0, the other master wins if requesting.
- gnt output equals the internal grant register, so it is a registered, glitch-free output.
- RTL is synchronous apart from async reset; no combinational path from slave ack to grant state.

Test Plan:
- Single master 0, 4 single reads at adr 0x100..0x10C, slave acks 1 cycle after stb:
  - gnt = 01 one cycle after cyc.
  - slave sees exactly 4 stb/ack pairs.
  - master 1 sees ack=0 throughout.
  - gnt = 00 one cycle after cyc drops.
- Both masters raise cyc in the same cycle after reset, FIXED_PRIO=0:
  - gnt = 01 first.
  - on master 0 release, gnt = 10 next edge.
  - master 1 write dat_ms=0xDEADBEEF appears at slave with its adr.
- Both masters continuously requesting with 2-beat cycles, FIXED_PRIO=0: grants alternate 01,10,01,10; 1000 cycles give each master 50% ±1 cycle of ownership.
- Same as previous with FIXED_PRIO=1: master 0 always wins ties; master 1 is granted only in cycles where master 0 cyc=0.
- Master 1 owns bus mid-burst (cti=010), assert sys_rst for 1 cycle asynchronously:
  - gnt = 00 and wshb_ifm.cyc = 0 immediately.
  - after release, master 0 wins the first tie (last = 1).
- Slave asserts err on master 0 beat 2: err reaches master 0 only, master 1 err stays 0, grant is held until master 0 drops cyc.

Source files
------------

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle with master and slave views.
interface wshb_if #(
  parameter int unsigned DATA_BYTES = 4
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone arbiter; grant is held for a whole cyc,
// selection is round-robin or fixed-priority on ties.
module wshb_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  wshb_if.slave        wshb_ifs_0,
  wshb_if.slave        wshb_ifs_1,
  wshb_if.master       wshb_ifm,
  output logic [1:0]   gnt
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1;

  assign req0 = wshb_ifs_0.cyc;
  assign req1 = wshb_ifs_1.cyc;

  // Tie goes to master 0 under fixed priority, otherwise to the master != lst.
  function automatic state_e pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1)  return (FIXED_PRIO || lst) ? StOwn0 : StOwn1;
    else if (r0)   return StOwn0;
    else if (r1)   return StOwn1;
    else           return StIdle;
  endfunction

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // An owner releasing cyc re-arbitrates in the same cycle, so a waiting
  // master is granted on the next edge without an idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = pick(req0, req1, last_q);
      StOwn0:  if (!req0) state_d = pick(1'b0, req1, 1'b0);
      StOwn1:  if (!req1) state_d = pick(req0, 1'b0, 1'b1);
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == StOwn0)      last_d = 1'b0;
    else if (state_d == StOwn1) last_d = 1'b1;
  end

  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      StOwn0:  gnt = 2'b01;
      StOwn1:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = '0;
    wshb_ifm.dat_ms = '0;
    wshb_ifm.sel    = '0;
    wshb_ifm.cti    = '0;
    wshb_ifm.bte    = '0;
    if (gnt[0]) begin
      wshb_ifm.cyc    = wshb_ifs_0.cyc;
      wshb_ifm.stb    = wshb_ifs_0.stb & wshb_ifs_0.cyc;
      wshb_ifm.we     = wshb_ifs_0.we;
      wshb_ifm.adr    = wshb_ifs_0.adr;
      wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
      wshb_ifm.sel    = wshb_ifs_0.sel;
      wshb_ifm.cti    = wshb_ifs_0.cti;
      wshb_ifm.bte    = wshb_ifs_0.bte;
    end else if (gnt[1]) begin
      wshb_ifm.cyc    = wshb_ifs_1.cyc;
      wshb_ifm.stb    = wshb_ifs_1.stb & wshb_ifs_1.cyc;
      wshb_ifm.we     = wshb_ifs_1.we;
      wshb_ifm.adr    = wshb_ifs_1.adr;
      wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
      wshb_ifm.sel    = wshb_ifs_1.sel;
      wshb_ifm.cti    = wshb_ifs_1.cti;
      wshb_ifm.bte    = wshb_ifs_1.bte;
    end
  end

  assign wshb_ifs_0.ack    = gnt[0] & wshb_ifm.ack;
  assign wshb_ifs_0.err    = gnt[0] & wshb_ifm.err;
  assign wshb_ifs_0.rty    = gnt[0] & wshb_ifm.rty;
  assign wshb_ifs_1.ack    = gnt[1] & wshb_ifm.ack;
  assign wshb_ifs_1.err    = gnt[1] & wshb_ifm.err;
  assign wshb_ifs_1.rty    = gnt[1] & wshb_ifm.rty;
  assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

endmodule
